// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-3 stream demultiplexer.
package stream_demux_pkg;

    typedef logic [1:0] route_sel_t;

    localparam route_sel_t SEL_OUT0    = 2'b00;
    localparam route_sel_t SEL_OUT1    = 2'b01;
    localparam route_sel_t SEL_OUT2    = 2'b10;
    localparam route_sel_t SEL_ILLEGAL = 2'b11;

    localparam int unsigned N_OUT = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: loads on request, drains on consumer ready,
// holds its data register when drained.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          slot_ready
);

    slot_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A load wins over a drain, so drain+load in one cycle stays FULL.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = SLOT_FULL;
        end else if (state == SLOT_FULL && out_ready) begin
            state_nxt = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= load_data;
        end
    end

    assign out_valid  = (state == SLOT_FULL);
    assign slot_ready = (state == SLOT_EMPTY) || out_ready;

endmodule

// File: rtl/stream_demux3.sv
// Registered 1-to-3 stream demux with per-output one-entry slots; select 11 is
// consumed and dropped. Define STREAM_DEMUX_DROP_CNT_EN for the drop_cnt port.
module stream_demux3
    import stream_demux_pkg::*;
#(
    parameter int unsigned DW = 8
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    parameter int unsigned CW = 8
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_sel,
    input  logic [DW-1:0] in_data,
    output logic [2:0]    out_valid,
    input  logic [2:0]    out_ready,
    output logic [DW-1:0] out_data0,
    output logic [DW-1:0] out_data1,
    output logic [DW-1:0] out_data2,
    output logic          drop
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [CW-1:0] drop_cnt
`endif
);

    route_sel_t          sel;
    logic [N_OUT-1:0]    load;
    logic [N_OUT-1:0]    slot_ready;
    logic                drop_accept;
    logic [DW-1:0]       slot_data [N_OUT];

    assign sel = in_sel;

    // Full parallel decode: each legal select touches only its own slot.
    always_comb begin
        load        = '0;
        in_ready    = 1'b0;
        drop_accept = 1'b0;
        case (sel)
            SEL_OUT0: begin
                in_ready = slot_ready[0];
                load[0]  = in_valid && slot_ready[0];
            end
            SEL_OUT1: begin
                in_ready = slot_ready[1];
                load[1]  = in_valid && slot_ready[1];
            end
            SEL_OUT2: begin
                in_ready = slot_ready[2];
                load[2]  = in_valid && slot_ready[2];
            end
            default: begin
                in_ready    = 1'b1;
                drop_accept = in_valid;
            end
        endcase
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        demux_slot #(
            .DW(DW)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[i]),
            .load_data  (in_data),
            .out_ready  (out_ready[i]),
            .out_valid  (out_valid[i]),
            .out_data   (slot_data[i]),
            .slot_ready (slot_ready[i])
        );
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            drop <= 1'b0;
        end else begin
            drop <= drop_accept;
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_accept && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux3.sv
// Directed + random bench for stream_demux3 with a per-output scoreboard queue.
module tb_stream_demux3;

    localparam int unsigned DW_TB = 8;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    localparam int unsigned CW_TB = 2;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [DW_TB-1:0] in_data;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [DW_TB-1:0] out_data0;
    logic [DW_TB-1:0] out_data1;
    logic [DW_TB-1:0] out_data2;
    logic             drop;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [CW_TB-1:0] drop_cnt;
    logic [CW_TB-1:0] exp_cnt;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [DW_TB-1:0] q0[$];
    logic [DW_TB-1:0] q1[$];
    logic [DW_TB-1:0] q2[$];
    logic [DW_TB-1:0] last0, last1, last2;
    logic             exp_drop;

    stream_demux3 #(
        .DW(DW_TB)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .CW(CW_TB)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .drop      (drop)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check in_ready before the edge, update the model at
    // the edge, then check every output just after it.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [DW_TB-1:0] d, input logic [2:0] ordy);
        logic [2:0] full;
        logic       exp_rdy;
        logic       acc;
        rst       = r;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        #1;
        full    = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
        exp_rdy = (s == 2'b11) ? 1'b1 : (!full[s] || ordy[s]);
        if (!r) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy && !r;
        @(posedge clk);
        if (r) begin
            q0.delete(); q1.delete(); q2.delete();
            last0 = '0; last1 = '0; last2 = '0;
            exp_drop = 1'b0;
`ifdef STREAM_DEMUX_DROP_CNT_EN
            exp_cnt = '0;
`endif
        end else begin
            if (ordy[0] && q0.size() != 0) void'(q0.pop_front());
            if (ordy[1] && q1.size() != 0) void'(q1.pop_front());
            if (ordy[2] && q2.size() != 0) void'(q2.pop_front());
            exp_drop = acc && (s == 2'b11);
`ifdef STREAM_DEMUX_DROP_CNT_EN
            if (exp_drop && exp_cnt != {CW_TB{1'b1}}) exp_cnt = exp_cnt + 1'b1;
`endif
            if (acc) begin
                case (s)
                    2'b00: begin q0.push_back(d); last0 = d; end
                    2'b01: begin q1.push_back(d); last1 = d; end
                    2'b10: begin q2.push_back(d); last2 = d; end
                    default: ;
                endcase
            end
        end
        #1;
        chk("out_valid", {29'd0, out_valid},
            {29'd0, q2.size() != 0, q1.size() != 0, q0.size() != 0});
        chk("out_data0", {24'd0, out_data0}, {24'd0, (q0.size() != 0) ? q0[0] : last0});
        chk("out_data1", {24'd0, out_data1}, {24'd0, (q1.size() != 0) ? q1[0] : last1});
        chk("out_data2", {24'd0, out_data2}, {24'd0, (q2.size() != 0) ? q2[0] : last2});
        chk("drop", {31'd0, drop}, {31'd0, exp_drop});
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_cnt));
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = '0; out_ready = 3'b000;
        last0 = '0; last1 = '0; last2 = '0; exp_drop = 1'b0;
`ifdef STREAM_DEMUX_DROP_CNT_EN
        exp_cnt = '0;
`endif
        // Reset state
        step(1'b1, 1'b0, 2'b00, 8'h00, 3'b000);
        step(1'b1, 1'b0, 2'b00, 8'h00, 3'b000);

        // Single word to out1
        step(1'b0, 1'b1, 2'b01, 8'hA5, 3'b111);
        step(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);

        // out0 stalled: second word blocked until consumer ready
        step(1'b0, 1'b1, 2'b00, 8'h11, 3'b110);
        step(1'b0, 1'b1, 2'b00, 8'h22, 3'b110);
        step(1'b0, 1'b1, 2'b00, 8'h22, 3'b110);
        step(1'b0, 1'b1, 2'b00, 8'h22, 3'b111);
        step(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);

        // Back-to-back drain+load on out2
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 2'b10, 8'(k), 3'b111);
        step(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);

        // Illegal select while out1 is stalled FULL; head-of-line on out1 only
        step(1'b0, 1'b1, 2'b01, 8'h77, 3'b101);
        step(1'b0, 1'b1, 2'b11, 8'hFF, 3'b101);
        step(1'b0, 1'b1, 2'b00, 8'h5C, 3'b101);
        step(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);

        // Fresh reset, then five drops in a row (saturation in the counter build)
        step(1'b1, 1'b0, 2'b00, 8'h00, 3'b000);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 2'b11, 8'hE0 + 8'(k), 3'b000);
        step(1'b0, 1'b0, 2'b11, 8'h00, 3'b000);

        // Reset with all three slots FULL
        step(1'b0, 1'b1, 2'b00, 8'h31, 3'b000);
        step(1'b0, 1'b1, 2'b01, 8'h32, 3'b000);
        step(1'b0, 1'b1, 2'b10, 8'h33, 3'b000);
        step(1'b1, 1'b0, 2'b00, 8'h00, 3'b000);
        step(1'b0, 1'b1, 2'b00, 8'h44, 3'b000);
        step(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
